gray_decode_pipe: RTL and testbench

- Pipelined, back-pressurable Gray-to-binary decoder; successor to the combinational decoder in libv.
- Splits the MSB-first prefix-XOR across STAGES register slices so wide codes close timing, and carries a valid/ready handshake on both sides.
- Optional continuity checker flags successive output codes that do not differ in exactly one bit, for Gray-coded pointer/counter streams (FIFO pointers, position encoders).

---
 rtl/gray_pkg.sv | 37 +++
 rtl/gray_decode_slice.sv | 66 ++++++
 rtl/gray_decode_pipe.sv | 114 +++++++++++
 tb/tb_gray_decode_pipe.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types and helpers for the pipelined Gray-to-binary decoder.
// Helpers work on MAX_W-bit vectors; callers zero-extend and truncate to W.
package gray_pkg;

  localparam int MAX_W = 256;

  // Bits per slice: ceil(w / stages).
  function automatic int seg_width(input int w, input int stages);
    return (w + stages - 1) / stages;
  endfunction

  // Resolves bits hi..lo of a Gray code MSB-first, starting from carry
  // (the decoded bit just above hi). Bits outside the segment come from dec_in.
  function automatic logic [MAX_W-1:0] gray_dec_seg(
    input logic [MAX_W-1:0] gray,
    input logic [MAX_W-1:0] dec_in,
    input logic             carry,
    input int               hi,
    input int               lo
  );
    logic [MAX_W-1:0] dec;
    logic             c;
    dec = dec_in;
    c   = carry;
    for (int i = hi; i >= lo; i--) begin
      c      = c ^ gray[i];
      dec[i] = c;
    end
    return dec;
  endfunction

  // True when exactly one bit of x is set.
  function automatic logic onehot_chk(input logic [MAX_W-1:0] x);
    return (x != '0) && ((x & (x - MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/gray_decode_slice.sv
// One pipeline slice: resolves decoded bits HI..LO and forwards the beat.
// An empty segment (HI < LO) only carries data and carry through.
module gray_decode_slice
  import gray_pkg::*;
#(
  parameter int W  = 32,
  parameter int LO = 0,
  parameter int HI = W - 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_vld,
  input  logic [W-1:0] up_gray,
  input  logic [W-1:0] up_dec,
  input  logic         up_carry,
  input  logic         dn_rdy,
  output logic         dn_vld,
  output logic [W-1:0] dn_gray,
  output logic [W-1:0] dn_dec,
  output logic         dn_carry
);

  logic         vld_q, vld_d;
  logic [W-1:0] gray_q, gray_d;
  logic [W-1:0] dec_q, dec_d;
  logic         carry_q, carry_d;
  logic         load;

  // NOTE: every always_comb output gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    load    = !vld_q || dn_rdy;
    vld_d   = load ? up_vld : vld_q;
    gray_d  = gray_q;
    dec_d   = dec_q;
    carry_d = carry_q;
    if (load && up_vld) begin
      gray_d  = up_gray;
      dec_d   = W'(gray_dec_seg(MAX_W'(up_gray), MAX_W'(up_dec), up_carry, HI, LO));
      carry_d = (HI >= LO) ? dec_d[LO] : up_carry;
    end
  end

  // NOTE: state updates use non-blocking assignments so every slice samples
  // its neighbour's pre-edge value. Data registers are reset too, because the
  // last slice drives out_dec/out_gray, which must read 0 during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= 1'b0;
      gray_q  <= '0;
      dec_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      vld_q   <= vld_d;
      gray_q  <= gray_d;
      dec_q   <= dec_d;
      carry_q <= carry_d;
    end
  end

  assign dn_vld   = vld_q;
  assign dn_gray  = gray_q;
  assign dn_dec   = dec_q;
  assign dn_carry = carry_q;

endmodule

// File: rtl/gray_decode_pipe.sv
// Pipelined, back-pressurable Gray-to-binary decoder with an optional
// continuity checker for single-bit-step Gray streams.
module gray_decode_pipe
  import gray_pkg::*;
#(
  parameter int W        = 32,
  parameter int STAGES   = 2,
  parameter int CHECK_EN = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         init,
  input  logic         in_vld,
  input  logic [W-1:0] in_gray,
  output logic         in_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_dec,
  output logic [W-1:0] out_gray,
  output logic         out_err,
  input  logic         out_rdy,
  output logic         err_sticky
);

  localparam int CW = seg_width(W, STAGES);

  // Index 0 is the input side; index s+1 is the output of slice s.
  logic         vld_s   [STAGES+1];
  logic [W-1:0] gray_s  [STAGES+1];
  logic [W-1:0] dec_s   [STAGES+1];
  logic         carry_s [STAGES+1];
  logic         rdy_s   [STAGES+1];

  assign vld_s[0]   = in_vld;
  assign gray_s[0]  = in_gray;
  assign dec_s[0]   = '0;
  assign carry_s[0] = 1'b0;

  // A slice can take a beat if it is empty or its content moves on this cycle.
  always_comb begin
    rdy_s[STAGES] = out_rdy;
    for (int s = STAGES - 1; s >= 0; s--) begin
      rdy_s[s] = !vld_s[s+1] || rdy_s[s+1];
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_slice
    localparam int HI     = W - 1 - s * CW;
    localparam int LO_RAW = W - (s + 1) * CW;
    localparam int LO     = (LO_RAW > 0) ? LO_RAW : 0;

    gray_decode_slice #(
      .W  (W),
      .LO (LO),
      .HI (HI)
    ) u_slice (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_vld   (vld_s[s]),
      .up_gray  (gray_s[s]),
      .up_dec   (dec_s[s]),
      .up_carry (carry_s[s]),
      .dn_rdy   (rdy_s[s+1]),
      .dn_vld   (vld_s[s+1]),
      .dn_gray  (gray_s[s+1]),
      .dn_dec   (dec_s[s+1]),
      .dn_carry (carry_s[s+1])
    );
  end

  assign in_rdy   = rdy_s[0];
  assign out_vld  = vld_s[STAGES];
  assign out_gray = gray_s[STAGES];
  assign out_dec  = dec_s[STAGES];

  logic [W-1:0] prev_q, prev_d;
  logic         have_prev_q, have_prev_d;
  logic         err_sticky_q, err_sticky_d;
  logic         out_hs;

  // init wins over a coincident handshake: the beat still seeds prev,
  // but its error is masked and the sticky flag is cleared.
  always_comb begin
    out_hs       = out_vld && out_rdy;
    out_err      = (CHECK_EN != 0) && !init && have_prev_q &&
                   !onehot_chk(MAX_W'(prev_q ^ out_gray));
    prev_d       = prev_q;
    have_prev_d  = have_prev_q;
    err_sticky_d = err_sticky_q;
    if (out_hs) begin
      prev_d       = out_gray;
      have_prev_d  = 1'b1;
      err_sticky_d = err_sticky_q | out_err;
    end
    if (init) begin
      have_prev_d  = out_hs;
      err_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q       <= '0;
      have_prev_q  <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      have_prev_q  <= have_prev_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_gray_decode_pipe.sv
// Directed bench for gray_decode_pipe (W=4, STAGES=2) plus random sweeps
// on W=13 instances with STAGES of 1, 3 and 13.
module tb_gray_decode_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       a_init, a_in_vld, a_in_rdy, a_out_vld, a_out_err, a_out_rdy, a_err_sticky;
  logic [3:0] a_in_gray, a_out_dec, a_out_gray;

  gray_decode_pipe #(.W(4), .STAGES(2), .CHECK_EN(1)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init       (a_init),
    .in_vld     (a_in_vld),
    .in_gray    (a_in_gray),
    .in_rdy     (a_in_rdy),
    .out_vld    (a_out_vld),
    .out_dec    (a_out_dec),
    .out_gray   (a_out_gray),
    .out_err    (a_out_err),
    .out_rdy    (a_out_rdy),
    .err_sticky (a_err_sticky)
  );

  logic        b_in_vld [3];
  logic [12:0] b_in_gray [3];
  logic        b_in_rdy [3];
  logic        b_out_vld [3];
  logic [12:0] b_out_dec [3];
  logic [12:0] b_out_gray [3];
  logic        b_out_err [3];
  logic        b_out_rdy [3];
  logic        b_err_sticky [3];

  for (genvar k = 0; k < 3; k++) begin : g_sweep
    gray_decode_pipe #(
      .W        (13),
      .STAGES   ((k == 0) ? 1 : ((k == 1) ? 3 : 13)),
      .CHECK_EN (0)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .init       (1'b0),
      .in_vld     (b_in_vld[k]),
      .in_gray    (b_in_gray[k]),
      .in_rdy     (b_in_rdy[k]),
      .out_vld    (b_out_vld[k]),
      .out_dec    (b_out_dec[k]),
      .out_gray   (b_out_gray[k]),
      .out_err    (b_out_err[k]),
      .out_rdy    (b_out_rdy[k]),
      .err_sticky (b_err_sticky[k])
    );
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [12:0] gdec13(input logic [12:0] g);
    logic [12:0] d;
    d[12] = g[12];
    for (int i = 11; i >= 0; i--) d[i] = d[i+1] ^ g[i];
    return d;
  endfunction

  task automatic sweep(input int k, input int stages);
    logic [12:0] q[$];
    logic [12:0] exp_g;
    int          lat;
    b_out_rdy[k] = 1'b1;
    b_in_vld[k]  = 1'b1;
    b_in_gray[k] = 13'($urandom);
    exp_g        = b_in_gray[k];
    tick();
    b_in_vld[k] = 1'b0;
    lat = 1;
    while (!b_out_vld[k] && lat < 40) begin
      tick();
      lat++;
    end
    check($sformatf("sweep%0d_latency", stages), lat, stages);
    check($sformatf("sweep%0d_lat_dec", stages), b_out_dec[k], gdec13(exp_g));
    tick();
    for (int c = 0; c < 300; c++) begin
      b_in_vld[k]  = ($urandom_range(3) != 0);
      b_in_gray[k] = 13'($urandom);
      b_out_rdy[k] = ($urandom_range(2) != 0);
      #1;
      if (b_out_vld[k] && b_out_rdy[k]) begin
        if (q.size() == 0) begin
          check($sformatf("sweep%0d_extra", stages), b_out_vld[k], 0);
        end else begin
          exp_g = q.pop_front();
          check($sformatf("sweep%0d_gray", stages), b_out_gray[k], exp_g);
          check($sformatf("sweep%0d_dec", stages), b_out_dec[k], gdec13(exp_g));
          check($sformatf("sweep%0d_err_off", stages), b_out_err[k], 0);
        end
      end
      if (b_in_vld[k] && b_in_rdy[k]) q.push_back(b_in_gray[k]);
      tick();
    end
    b_in_vld[k]  = 1'b0;
    b_out_rdy[k] = 1'b1;
    for (int c = 0; c < 40 && q.size() > 0; c++) begin
      #1;
      if (b_out_vld[k]) begin
        exp_g = q.pop_front();
        check($sformatf("sweep%0d_drain_gray", stages), b_out_gray[k], exp_g);
        check($sformatf("sweep%0d_drain_dec", stages), b_out_dec[k], gdec13(exp_g));
      end
      tick();
    end
    check($sformatf("sweep%0d_left", stages), q.size(), 0);
    check($sformatf("sweep%0d_idle", stages), b_out_vld[k], 0);
    check($sformatf("sweep%0d_sticky_off", stages), b_err_sticky[k], 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    rst_n     = 1'b0;
    a_init    = 1'b0;
    a_in_vld  = 1'b0;
    a_in_gray = '0;
    a_out_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      b_in_vld[k]  = 1'b0;
      b_in_gray[k] = '0;
      b_out_rdy[k] = 1'b1;
    end

    // Reset state
    @(negedge clk);
    check("rst_out_vld", a_out_vld, 0);
    check("rst_in_rdy", a_in_rdy, 1);
    check("rst_out_dec", a_out_dec, 0);
    check("rst_out_gray", a_out_gray, 0);
    check("rst_out_err", a_out_err, 0);
    check("rst_sticky", a_err_sticky, 0);
    rst_n = 1'b1;

    // Latency 2 and basic decode
    a_in_vld = 1'b1; a_in_gray = 4'b0110;
    tick();
    a_in_vld = 1'b0;
    check("lat1_out_vld", a_out_vld, 0);
    tick();
    check("lat2_out_vld", a_out_vld, 1);
    check("dec_0110", a_out_dec, 4'b0100);
    check("err_first_beat", a_out_err, 0);
    a_in_vld = 1'b1; a_in_gray = 4'b1000;
    tick();
    a_in_vld = 1'b0;
    check("bubble_out_vld", a_out_vld, 0);
    tick();
    check("dec_1000", a_out_dec, 4'b1111);
    check("err_1000_after_0110", a_out_err, 1);
    tick();
    check("sticky_set", a_err_sticky, 1);
    a_init = 1'b1;
    tick();
    a_init = 1'b0;
    check("init_clears_sticky", a_err_sticky, 0);

    // Back-to-back stream, one beat per cycle
    a_in_vld = 1'b1; a_in_gray = 4'b0000;
    tick();
    a_in_gray = 4'b0001;
    tick();
    check("stream0_dec", a_out_dec, 0); check("stream0_err", a_out_err, 0);
    a_in_gray = 4'b0011;
    tick();
    check("stream1_vld", a_out_vld, 1);
    check("stream1_dec", a_out_dec, 1); check("stream1_err", a_out_err, 0);
    a_in_gray = 4'b0010;
    tick();
    check("stream2_dec", a_out_dec, 2); check("stream2_err", a_out_err, 0);
    a_in_gray = 4'b0111;
    tick();
    a_in_vld = 1'b0;
    check("stream3_dec", a_out_dec, 3); check("stream3_err", a_out_err, 0);
    check("stream3_sticky", a_err_sticky, 0);
    tick();
    check("jump_dec", a_out_dec, 5); check("jump_err", a_out_err, 1);
    tick();
    check("jump_sticky", a_err_sticky, 1);
    check("jump_drained", a_out_vld, 0);
    a_init = 1'b1;
    tick();
    a_init = 1'b0;

    // Back-pressure: capacity is STAGES beats, outputs held while stalled
    a_out_rdy = 1'b0; a_in_vld = 1'b1; acc = 0;
    for (int c = 0; c < 6; c++) begin
      a_in_gray = (acc == 0) ? 4'b0100 : 4'b1100;
      #1;
      if (a_in_rdy) acc++;
      if (c >= 2) begin
        check("stall_vld", a_out_vld, 1);
        check("stall_dec", a_out_dec, 4'b0111);
      end
      tick();
    end
    check("stall_accepted", acc, 2);
    check("stall_in_rdy", a_in_rdy, 0);
    check("stall_gray", a_out_gray, 4'b0100);
    a_in_vld = 1'b0; a_out_rdy = 1'b1;
    #1;
    check("drain0_dec", a_out_dec, 7); check("drain0_err", a_out_err, 0);
    tick();
    check("drain1_vld", a_out_vld, 1);
    check("drain1_dec", a_out_dec, 8); check("drain1_err", a_out_err, 0);
    tick();
    check("drain_idle", a_out_vld, 0);

    // Repeated code is an error
    a_init = 1'b1;
    tick();
    a_init = 1'b0;
    a_in_vld = 1'b1; a_in_gray = 4'b0011;
    tick();
    tick();
    a_in_vld = 1'b0;
    check("rep0_dec", a_out_dec, 4'b0010); check("rep0_err", a_out_err, 0);
    tick();
    check("rep1_dec", a_out_dec, 4'b0010); check("rep1_err", a_out_err, 1);
    tick();
    check("rep_sticky", a_err_sticky, 1);

    // Same pair, with init coincident with the second handshake
    a_init = 1'b1;
    tick();
    a_init = 1'b0;
    a_in_vld = 1'b1; a_in_gray = 4'b0011;
    tick();
    tick();
    a_in_vld = 1'b0;
    check("irep0_err", a_out_err, 0);
    tick();
    a_init = 1'b1;
    #1;
    check("init_hs_err_masked", a_out_err, 0);
    tick();
    a_init = 1'b0;
    check("init_hs_sticky", a_err_sticky, 0);
    a_in_vld = 1'b1; a_in_gray = 4'b0011;
    tick();
    a_in_vld = 1'b0;
    tick();
    check("init_hs_prev_kept", a_out_err, 1);
    tick();
    check("pre_rst_sticky", a_err_sticky, 1);

    // Asynchronous reset with beats in flight
    a_out_rdy = 1'b0; a_in_vld = 1'b1; a_in_gray = 4'b0101;
    tick();
    tick();
    a_in_vld = 1'b0;
    check("inflight_vld", a_out_vld, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_vld", a_out_vld, 0);
    check("midrst_in_rdy", a_in_rdy, 1);
    check("midrst_out_dec", a_out_dec, 0);
    check("midrst_out_gray", a_out_gray, 0);
    check("midrst_sticky", a_err_sticky, 0);
    tick();
    rst_n = 1'b1; a_out_rdy = 1'b1;
    a_in_vld = 1'b1; a_in_gray = 4'b1111;
    tick();
    a_in_vld = 1'b0;
    tick();
    check("postrst_vld", a_out_vld, 1);
    check("postrst_dec", a_out_dec, 4'b1010);
    check("postrst_err", a_out_err, 0);
    tick();
    check("postrst_no_ghost", a_out_vld, 0);

    // Random sweeps against a prefix-XOR model
    sweep(0, 1);
    sweep(1, 3);
    sweep(2, 13);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
